// File: rtl/mem_port_pkg.sv
// Shared constants and request type for the M20K port initiator.
package mem_port_pkg;
  localparam int MEM_ADDR_W = 13;
  localparam int MEM_DATA_W = 2;
  localparam int RD_LAT     = 1;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_DATA_W-1:0] wmask;
  } mem_req_t;
endpackage

// File: rtl/mem_rsp_fifo.sv
// Circular response FIFO with occupancy count; the producer guarantees no push
// while full.
module mem_rsp_fifo #(
  parameter  int DATA_W = 2,
  parameter  int DEPTH  = 3,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              empty, full, do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign do_pop = pop & ~empty;
  assign head   = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage needs no reset: count gates what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  push_while_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

// File: rtl/mem_port_initiator.sv
// Valid/ready initiator for one M20K macro port with credit-protected response FIFO.
// Optional: MEM_PORT_INIT_WRACK_EN makes accepted writes return a zero response entry.
module mem_port_initiator
  import mem_port_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int RSP_DEPTH = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              CE,
  output logic              WE,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] WEM,
  input  logic [DATA_W-1:0] Q
);
  localparam int FCNT_W = $clog2(RSP_DEPTH + 1);
  localparam int CNT_W  = $clog2(RSP_DEPTH + RD_LAT + 1);

  logic              run;
  logic              acc, vld_in, push, pop;
  logic [RD_LAT:1]   vld_pipe;
  logic [DATA_W-1:0] push_data;
  logic [FCNT_W-1:0] fifo_count;
  logic [CNT_W-1:0]  cnt;

  // Credit only sees registered state, so ready never depends on payload or rsp_ready.
  assign cnt       = CNT_W'(fifo_count) + CNT_W'($countones(vld_pipe));
  assign req_ready = run & (cnt < CNT_W'(RSP_DEPTH));
  assign acc       = req_valid & req_ready;

  assign CE  = acc;
  assign WE  = acc & req_we;
  assign A   = req_addr;
  assign D   = req_wdata;
  assign WEM = req_wmask;

`ifdef MEM_PORT_INIT_WRACK_EN
  logic [RD_LAT:1] wr_pipe;

  assign vld_in    = acc;
  assign push_data = wr_pipe[RD_LAT] ? '0 : Q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) wr_pipe <= '0;
    else        wr_pipe <= (wr_pipe << 1) | RD_LAT'(acc & req_we);
  end
`else
  assign vld_in    = acc & ~req_we;
  assign push_data = Q;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      run      <= 1'b0;
      vld_pipe <= '0;
    end else begin
      run      <= 1'b1;
      vld_pipe <= (vld_pipe << 1) | RD_LAT'(vld_in);
    end
  end

  assign push      = vld_pipe[RD_LAT];
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid & rsp_ready;

  mem_rsp_fifo #(.DATA_W(DATA_W), .DEPTH(RSP_DEPTH)) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (rsp_rdata),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_mem_port_initiator.sv
// Randomized + directed bench: macro model drives Q, scoreboard predicts ready/CE/responses.
module tb_mem_port_initiator;
  import mem_port_pkg::*;

  localparam int AW    = MEM_ADDR_W;
  localparam int DW    = MEM_DATA_W;
  localparam int DEPTH = 3;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0, req_wmask = '0;
  logic          req_ready, rsp_valid, CE, WE;
  logic [DW-1:0] rsp_rdata, D, WEM, Q;
  logic [AW-1:0] A;

  mem_port_initiator #(.ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .CE(CE), .WE(WE), .A(A), .D(D), .WEM(WEM), .Q(Q)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 32'h1A5 || a == 32'h10) return 2'b10;
    return DW'(a % 4);
  endfunction

  // Macro port model: registered inputs, Q valid the cycle after a read.
  bit   [DW-1:0] mmem [1<<AW];
  bit            mset [1<<AW];
  logic [DW-1:0] q_r = '0;
  assign Q = q_r;

  function automatic logic [DW-1:0] mrd(input logic [AW-1:0] a);
    return mset[a] ? mmem[a] : init_val(int'(a));
  endfunction

  always @(posedge CLK) begin
    if (CE) begin
      if (WE) begin
        mmem[A] = (mrd(A) & ~WEM) | (D & WEM);
        mset[A] = 1'b1;
      end else begin
        q_r <= mrd(A);
      end
    end
  end

  // Reference model: memory contents and ordered list of owed responses.
  typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
  logic [DW-1:0] rmem [int];
  exp_t          expq [$];
  int            cyc = 0;
  bit            up = 1'b0;
  bit            acc_m;
  int            n_tests = 0, n_fail = 0;

  function automatic logic [DW-1:0] rrd(input int a);
    return rmem.exists(a) ? rmem[a] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive(input bit v, input mem_req_t r);
    req_valid = v;
    req_we    = r.we;
    req_addr  = r.addr;
    req_wdata = r.wdata;
    req_wmask = r.wmask;
  endtask

  // One clock: check outputs mid-cycle, update model, advance to next negedge.
  task automatic tick();
    logic exp_rdy, exp_rv;
    int   a;
    #1;
    exp_rdy = up && (expq.size() < DEPTH);
    chk("req_ready", req_ready, exp_rdy);
    acc_m = req_valid && exp_rdy;
    chk("ce", CE, acc_m);
    if (acc_m) begin
      chk("we", WE, req_we);
      chk("addr", A, req_addr);
      chk("d", D, req_wdata);
      chk("wem", WEM, req_wmask);
    end
    exp_rv = (expq.size() > 0) && (expq[0].cyc + 2 <= cyc);
    chk("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv) chk("rsp_rdata", rsp_rdata, expq[0].data);
    if (exp_rv && rsp_ready) void'(expq.pop_front());
    if (acc_m) begin
      a = int'(req_addr);
      if (req_we) begin
        rmem[a] = (rrd(a) & ~req_wmask) | (req_wdata & req_wmask);
`ifdef MEM_PORT_INIT_WRACK_EN
        expq.push_back('{data: '0, cyc: cyc});
`endif
      end else begin
        expq.push_back('{data: rrd(a), cyc: cyc});
      end
    end
    @(posedge CLK);
    cyc++;
    if (RST_N) up = 1'b1;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_ce", CE, 1'b0);
    expq.delete();
    up = 1'b0;
    tick();
    RST_N = 1'b1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0);
    repeat (n) tick();
  endtask

  initial begin
    int n;
    mem_req_t r;
    @(negedge CLK);
    // Reset state
    drive(1'b1, '{we: 1'b0, addr: 13'h1A5, wdata: '0, wmask: '0});
    tick();
    tick();
    RST_N = 1'b1;
    idle(2);

    // Single read of 0x1A5
    rsp_ready = 1'b1;
    drive(1'b1, '{we: 1'b0, addr: 13'h1A5, wdata: '0, wmask: '0});
    tick();
    idle(4);

    // Streaming: 8 back-to-back reads
    n = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, '{we: 1'b0, addr: AW'(i), wdata: '0, wmask: '0});
      tick();
      if (acc_m) n++;
    end
    chk("stream_acc", n, 8);
    idle(4);

    // Backpressure: only DEPTH reads accepted while stalled
    rsp_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, '{we: 1'b0, addr: AW'(n), wdata: '0, wmask: '0});
      tick();
      if (acc_m) n++;
    end
    chk("bp_acc", n, 3);
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && n < 5; i++) begin
      drive(1'b1, '{we: 1'b0, addr: AW'(n), wdata: '0, wmask: '0});
      tick();
      if (acc_m) n++;
    end
    chk("bp_total", n, 5);
    idle(5);

    // Masked write then read-back
    drive(1'b1, '{we: 1'b1, addr: 13'h10, wdata: 2'b01, wmask: 2'b01});
    tick();
    drive(1'b1, '{we: 1'b0, addr: 13'h10, wdata: '0, wmask: '0});
    tick();
    idle(4);

    // Write then read of 0x3 (ack ordering when write acks are enabled)
    drive(1'b1, '{we: 1'b1, addr: 13'h3, wdata: 2'b11, wmask: 2'b11});
    tick();
    drive(1'b1, '{we: 1'b0, addr: 13'h3, wdata: '0, wmask: '0});
    tick();
    idle(4);

    // Reset with reads outstanding
    rsp_ready = 1'b0;
    drive(1'b1, '{we: 1'b0, addr: 13'h5, wdata: '0, wmask: '0});
    tick();
    tick();
    do_reset();
    rsp_ready = 1'b1;
    idle(5);

    // Randomized traffic with one mid-run reset
    for (int i = 0; i < 600; i++) begin
      r.we    = ($urandom % 3) == 0;
      r.addr  = AW'($urandom % 16);
      r.wdata = DW'($urandom);
      r.wmask = DW'($urandom);
      drive(($urandom % 4) != 0, r);
      rsp_ready = ($urandom % 3) != 0;
      if (i == 300) do_reset();
      else tick();
    end
    rsp_ready = 1'b1;
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_initiator.md
Name: mem_port_initiator

Overview:
- Initiator for one port of the dual-port M20K macro wrappers (CE/WE/A/D/WEM/Q port style).
- Accepts read/write requests on a valid/ready channel and drives the macro port.
- Tracks the macro's one-cycle read latency (unregistered Q) and returns read data in order on a valid/ready response channel.
- Never drops data under backpressure.
- Sits between datapath engines and each macro port; one instance per port (A0/A1 side).

Parameters:
- ADDR_W, 13, macro address width.
- DATA_W, 2, macro data width.
- RSP_DEPTH, 3, response buffer entries; minimum 2, and 3 gives full throughput.

Ports:
- CLK  in  1  single clock, shared with the macro.
- RST_N  in  1  asynchronous active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- req_wmask  in  DATA_W  per-bit write mask.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes rsp_rdata.
- rsp_rdata  out  DATA_W  read data, in request order.
- CE  out  1  macro port enable.
- WE  out  1  macro write enable.
- A  out  ADDR_W  macro address.
- D  out  DATA_W  macro write data.
- WEM  out  DATA_W  macro write mask.
- Q  in  DATA_W  macro read data; valid one cycle after a read issue.

Behaviour:
- Issue path:
  - acc = req_valid & req_ready.
  - CE = acc; WE = acc & req_we.
  - A/D/WEM are driven from req_addr/req_wdata/req_wmask.
  - CE is never asserted unless acc.
  - The macro registers these signals on CLK.
- Pending register rd_pend:
  - Set on the edge that accepts a read; otherwise cleared.
  - In the cycle where rd_pend=1, Q is pushed into the response FIFO.
- Credit:
  - cnt = fifo_count + rd_pend.
  - req_ready = (cnt < RSP_DEPTH), registered-state only; no combinational path from rsp_ready or req_* to req_ready.
  - Writes also require credit, so ready does not depend on payload.
- Latency: read accepted at edge t → Q valid in cycle t+1 → rsp_valid at cycle t+2. Writes complete at edge t and produce no response.
- Throughput: with RSP_DEPTH=3 and rsp_ready held 1, one request per cycle sustained indefinitely.
- FIFO:
  - Circular, with pointer wrap at RSP_DEPTH.
  - rsp_valid = fifo_count != 0; rsp_rdata = head entry (registered storage).
  - Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle keeps count unchanged.
  - Overflow is impossible by credit; an assertion fires if a push occurs while full.
- Ordering: responses leave in acceptance order; write/read interleaving is preserved by the macro (same port, new-data semantics).
- Reset (RST_N low, any time, async):
  - rd_pend=0, fifo_count=0, pointers=0.
  - rsp_valid=0, req_ready=0 while in reset, then 1 from the first cycle after release.
  - CE=WE=0.
  - In-flight reads are discarded; Q arriving after reset is ignored.
- rsp_ready high with FIFO empty: no effect.

Optional Feature:
- MEM_PORT_INIT_WRACK_EN defined:
  - Accepted writes also push a response entry, with rsp_rdata = 0, in order with reads.
  - The entry is pushed one cycle after acceptance, identical to read timing, with rd_pend generalised to "any access pending".
- Undefined: writes produce no response (as above).

Decomposition:
- Package mem_port_pkg holds:
  - default ADDR_W/DATA_W constants;
  - typedef mem_req_t {we, addr, wdata, wmask};
  - localparam for the read latency (1).
- One sub-module, mem_rsp_fifo: parameterised DATA_W × RSP_DEPTH synchronous FIFO with count output, async active-low reset.

Test Plan:
- Single read: memory model holds addr 0x1A5 = 2'b10; read accepted at cycle 0 → CE=1, WE=0, A=0x1A5 in cycle 0; rsp_valid=1, rsp_rdata=2'b10 at cycle 2.
- Streaming: 8 back-to-back reads, addresses 0..7 holding i%4, rsp_ready=1 → req_ready never drops; 8 responses in order, 0,1,2,3,0,1,2,3.
- Backpressure: rsp_ready=0, 5 reads offered → exactly 3 accepted, then req_ready=0 with no CE; raise rsp_ready → remaining 2 accepted; all 5 returned in order.
- Masked write: addr 0x10 holds 2'b10; write D=2'b01, WEM=2'b01, then read 0x10 → rsp_rdata=2'b11; write produces no response.
- Reset mid-op: 2 reads outstanding with rsp_ready=0, drop RST_N for 1 cycle → rsp_valid=0 and CE=0 immediately; after release req_ready=1 and no stale responses appear.
- WRACK (macro defined): write to 0x3, then read 0x3 → two responses in order: 2'b00 (ack) at cycle 2, then read data at cycle 3.
